// File: rtl/hash_uart_tx_pkg.sv
// Shared definitions for the hash UART link: FSM state encoding, frame
// geometry and the default preamble byte.
package hash_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SYNC,
    ST_REQ_WORD,
    ST_WAIT_WORD,
    ST_SEND_WORD,
    ST_SEND_CSUM,
    ST_DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         FRAME_BYTES    = 34;
  localparam int         WORDS_PER_HASH = 8;

  // Words go out MSB byte first.
  function automatic logic [7:0] msb_byte(input logic [31:0] w);
    return w[31:24];
  endfunction

endpackage

// File: rtl/hash_uart_tx_if.sv
// Handshake/bus bundle between the hash FIFO read side, the frame
// requester and the UART transmitter.
//   start       : one-cycle request to send a hash frame
//   data_in     : 32-bit word from the hash FIFO
//   data_valid  : data_in valid this cycle
//   rd_en       : one-cycle word request to the hash FIFO
//   tx          : UART line (idle high, 8N1, LSB first)
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after a complete frame
//   timeout_err : sticky FIFO response timeout flag
interface hash_uart_tx_if;
  logic        start;
  logic [31:0] data_in;
  logic        data_valid;
  logic        rd_en;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  modport master (
    output start, data_in, data_valid,
    input  rd_en, tx, busy, frame_done, timeout_err
  );

  modport slave (
    input  start, data_in, data_valid,
    output rd_en, tx, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/hash_uart_tx_byte.sv
// Single-byte 8N1 UART serialiser. Owns the baud and bit counters.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load byte_i and start a byte (accepted when idle or in the
//              final cycle of the previous stop bit, giving zero gap)
//   byte_i   : byte to send, LSB first
//   done_o   : high in the last cycle of the stop bit
//   tx_o     : registered UART line
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic       tx_o
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] baud_q;
  logic [3:0]  bit_q;    // 0 start, 1..8 data, 9 stop
  logic [7:0]  shr_q;
  logic        active_q;
  logic        tx_q;
  logic        bit_end;

  assign bit_end = active_q && (baud_q == '0);
  assign done_o  = bit_end && (bit_q == 4'd9);
  assign tx_o    = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shr_q    <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load_i && (!active_q || done_o)) begin
      baud_q   <= RELOAD;
      bit_q    <= '0;
      shr_q    <= byte_i;
      active_q <= 1'b1;
      tx_q     <= 1'b0;
    end else if (!active_q) begin
      baud_q <= RELOAD;
    end else if (bit_end) begin
      baud_q <= RELOAD;
      if (bit_q == 4'd9) begin
        active_q <= 1'b0;
        tx_q     <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
        if (bit_q == 4'd8) begin
          tx_q <= 1'b1;
        end else begin
          tx_q  <= shr_q[0];
          shr_q <= {1'b0, shr_q[7:1]};
        end
      end
    end else begin
      baud_q <= baud_q - 16'd1;
    end
  end
endmodule

// File: rtl/hash_uart_tx.sv
// Frames a 256-bit hash pulled word by word from a FIFO and sends it over
// UART: SYNC_BYTE, 32 hash bytes (MSB byte of each word first), XOR checksum.
//   clk, rst : clock (shared with FIFO read side), async active-high reset
//   bus      : hash_uart_tx_if slave (start/data_in/data_valid in,
//              rd_en/tx/busy/frame_done/timeout_err out)
module hash_uart_tx
  import hash_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         RESP_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  hash_uart_tx_if.slave bus
);
  localparam logic [15:0] TMO_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [2:0]  LAST_WORD = 3'(WORDS_PER_HASH - 1);

  state_t      state_q, state_d;
  logic [2:0]  word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] buf_q, buf_d;
  logic [15:0] tmo_q, tmo_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic        terr_q, terr_d;
  logic        load;
  logic [7:0]  load_byte;
  logic        bdone;
  logic        tx_w;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .byte_i (load_byte),
    .done_o (bdone),
    .tx_o   (tx_w)
  );

  assign bus.tx          = tx_w;
  assign bus.rd_en       = rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = fdone_q;
  assign bus.timeout_err = terr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      buf_q   <= '0;
      tmo_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      terr_q  <= terr_d;
    end
  end

  // Each next byte is loaded in the same cycle the serialiser reports its
  // stop bit done, so bytes within a word and the checksum follow with no gap.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    bidx_d    = bidx_q;
    csum_d    = csum_q;
    buf_d     = buf_q;
    tmo_d     = tmo_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    fdone_d   = 1'b0;
    terr_d    = terr_q;
    load      = 1'b0;
    load_byte = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !busy_q) begin
          state_d   = ST_SEND_SYNC;
          busy_d    = 1'b1;
          word_d    = '0;
          bidx_d    = '0;
          csum_d    = '0;
          terr_d    = 1'b0;
          load      = 1'b1;
          load_byte = SYNC_BYTE;
        end
      end
      ST_SEND_SYNC: begin
        if (bdone) begin
          state_d = ST_REQ_WORD;
          rd_en_d = 1'b1;
        end
      end
      ST_REQ_WORD: begin
        state_d = ST_WAIT_WORD;
        tmo_d   = '0;
      end
      ST_WAIT_WORD: begin
        if (bus.data_valid) begin
          buf_d     = bus.data_in;
          load      = 1'b1;
          load_byte = msb_byte(bus.data_in);
          csum_d    = csum_q ^ msb_byte(bus.data_in);
          bidx_d    = '0;
          state_d   = ST_SEND_WORD;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_SEND_WORD: begin
        if (bdone) begin
          if (bidx_q == 2'd3) begin
            word_d = word_q + 3'd1;
            if (word_q == LAST_WORD) begin
              load      = 1'b1;
              load_byte = csum_q;
              state_d   = ST_SEND_CSUM;
            end else begin
              state_d = ST_REQ_WORD;
              rd_en_d = 1'b1;
            end
          end else begin
            bidx_d    = bidx_q + 2'd1;
            buf_d     = {buf_q[23:0], 8'h00};
            load      = 1'b1;
            load_byte = msb_byte({buf_q[23:0], 8'h00});
            csum_d    = csum_q ^ msb_byte({buf_q[23:0], 8'h00});
          end
        end
      end
      ST_SEND_CSUM: begin
        if (bdone) begin
          state_d = ST_DONE;
          fdone_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_hash_uart_tx.sv
module tb_hash_uart_tx;
  import hash_link_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_uart_tx_if bus();

  hash_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .RESP_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] words [8];
  logic [7:0]  exp_b [FRAME_BYTES];
  logic [7:0]  rx_q [$];
  int  bad_timing = 0, rd_cnt = 0, fd_cnt = 0;
  int  withhold_req = 0, req_num = 0, widx = 0, rd_cyc_last = 0;
  int  t_start = 0;
  bit  stray_en = 0, pend = 0;

  // Expected frame from the word table: sync, bytes MSB-first, XOR checksum.
  function automatic void fill_expected();
    logic [7:0] c;
    c = 8'h00;
    exp_b[0] = 8'hA5;
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 4; k++) begin
        exp_b[1 + 4*w + k] = words[w][31 - 8*k -: 8];
        c = c ^ words[w][31 - 8*k -: 8];
      end
    exp_b[33] = c;
  endfunction

  // UART receiver: every bit must hold for exactly CPB cycles.
  initial begin : rx_mon
    logic [7:0] b;
    bit ok, aborted;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx === 1'b0) begin
        ok = 1; aborted = 0; b = '0;
        for (int i = 1; i < CPB; i++) begin
          @(negedge clk); if (rst) aborted = 1; if (bus.tx !== 1'b0) ok = 0;
        end
        for (int k = 0; k < 8; k++)
          for (int c = 0; c < CPB; c++) begin
            @(negedge clk); if (rst) aborted = 1;
            if (c == 0) b[k] = bus.tx; else if (bus.tx !== b[k]) ok = 0;
          end
        for (int c = 0; c < CPB; c++) begin
          @(negedge clk); if (rst) aborted = 1; if (bus.tx !== 1'b1) ok = 0;
        end
        if (!aborted) begin
          rx_q.push_back(b);
          if (!ok) bad_timing++;
        end
      end
    end
  end

  initial begin : pulse_counter
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rd_en === 1'b1) rd_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
      end
    end
  end

  // FIFO read side: answers each rd_en one cycle later, except the withheld one.
  initial begin : fifo_model
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    forever begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      if (pend) begin
        bus.data_valid = 1'b1;
        bus.data_in    = words[widx % 8];
        widx++;
        pend = 0;
      end else if (stray_en && (cyc % 5 == 0)) begin
        bus.data_valid = 1'b1;
        bus.data_in    = 32'hDEAD_BEEF;
      end
      if (!rst && bus.rd_en === 1'b1) begin
        req_num++;
        rd_cyc_last = cyc;
        if (req_num != withhold_req) pend = 1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic clear_frame();
    rx_q.delete();
    rd_cnt = 0; fd_cnt = 0; req_num = 0; widx = 0; bad_timing = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int at);
    seen = 0; at = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin seen = 1; at = cyc; end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL rst_tx: got %b expected 1", bus.tx); else n_pass++;
    n_checks++; if (bus.rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", bus.rd_en); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b expected 0", bus.timeout_err); else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL idle_tx: got %b expected 1", bus.tx); else n_pass++;
  endtask

  task automatic test_incrementing();
    bit seen; int at;
    for (int w = 0; w < 8; w++) words[w] = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
    fill_expected();
    clear_frame();
    pulse_start();
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL inc_busy_rise: got %b expected 1", bus.busy); else n_pass++;
    wait_done(seen, at);
    n_checks++; if (!seen) $display("FAIL inc_frame_done: got 0 expected 1"); else n_pass++;
    // 34 bytes of 40 cycles, 2 idle cycles per word request, 1 cycle to DONE.
    n_checks++; if (at - t_start != 1377) $display("FAIL inc_latency: got %0d expected 1377", at - t_start); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL inc_busy_fall: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (rx_q.size() != 34) $display("FAIL inc_len: got %0d expected 34", rx_q.size()); else n_pass++;
    for (int i = 0; i < 34; i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== exp_b[i]) $display("FAIL inc_byte%0d: got %h expected %h", i, g, exp_b[i]); else n_pass++;
    end
    n_checks++; if (rx_q.size() < 34 || rx_q[33] !== 8'h00) $display("FAIL inc_csum: got %h expected 00", (rx_q.size() < 34) ? 8'hxx : rx_q[33]); else n_pass++;
    n_checks++; if (rd_cnt != 8) $display("FAIL inc_rd_en_count: got %0d expected 8", rd_cnt); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL inc_frame_done_count: got %0d expected 1", fd_cnt); else n_pass++;
    n_checks++; if (bad_timing != 0) $display("FAIL inc_bit_timing: got %0d bad bytes expected 0", bad_timing); else n_pass++;
  endtask

  task automatic test_all_ff();
    bit seen; int at;
    for (int w = 0; w < 7; w++) words[w] = 32'hFFFF_FFFF;
    words[7] = 32'hFFFF_FF00;
    fill_expected();
    clear_frame();
    pulse_start();
    wait_done(seen, at);
    repeat (5) @(negedge clk);
    n_checks++; if (!seen) $display("FAIL ff_frame_done: got 0 expected 1"); else n_pass++;
    n_checks++; if (rx_q.size() != 34) $display("FAIL ff_len: got %0d expected 34", rx_q.size()); else n_pass++;
    for (int i = 0; i < 34; i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== exp_b[i]) $display("FAIL ff_byte%0d: got %h expected %h", i, g, exp_b[i]); else n_pass++;
    end
    n_checks++; if (rx_q.size() < 34 || rx_q[33] !== 8'hFF) $display("FAIL ff_csum: got %h expected ff", (rx_q.size() < 34) ? 8'hxx : rx_q[33]); else n_pass++;
    n_checks++; if (bad_timing != 0) $display("FAIL ff_bit_timing: got %0d bad bytes expected 0", bad_timing); else n_pass++;
  endtask

  task automatic test_timeout();
    bit seen, fseen; int at, fat;
    for (int w = 0; w < 8; w++) words[w] = 32'h1234_5670 + 32'(w);
    fill_expected();
    clear_frame();
    withhold_req = 3;
    pulse_start();
    seen = 0; at = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus.timeout_err === 1'b1) begin seen = 1; at = cyc; end
    end
    n_checks++; if (!seen) $display("FAIL to_flag: got 0 expected 1"); else n_pass++;
    // 16 waiting cycles after the rd_en cycle, flag registered on the next.
    n_checks++; if (at - rd_cyc_last != 17) $display("FAIL to_delay: got %0d expected 17", at - rd_cyc_last); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL to_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL to_tx: got %b expected 1", bus.tx); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (bus.timeout_err !== 1'b1) $display("FAIL to_sticky: got %b expected 1", bus.timeout_err); else n_pass++;
    n_checks++; if (fd_cnt != 0) $display("FAIL to_no_frame_done: got %0d expected 0", fd_cnt); else n_pass++;
    n_checks++; if (rd_cnt != 3) $display("FAIL to_rd_en_count: got %0d expected 3", rd_cnt); else n_pass++;
    n_checks++; if (rx_q.size() != 9) $display("FAIL to_partial_len: got %0d expected 9", rx_q.size()); else n_pass++;
    withhold_req = 0;
    clear_frame();
    pulse_start();
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL to_cleared: got %b expected 0", bus.timeout_err); else n_pass++;
    wait_done(fseen, fat);
    repeat (5) @(negedge clk);
    n_checks++; if (!fseen) $display("FAIL to_retry_done: got 0 expected 1"); else n_pass++;
    n_checks++; if (rx_q.size() != 34) $display("FAIL to_retry_len: got %0d expected 34", rx_q.size()); else n_pass++;
    for (int i = 0; i < 34; i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== exp_b[i]) $display("FAIL to_retry_byte%0d: got %h expected %h", i, g, exp_b[i]); else n_pass++;
    end
  endtask

  task automatic test_ignored_inputs();
    bit seen; int at;
    for (int w = 0; w < 8; w++) words[w] = 32'hCAFE_0000 ^ {8'(w), 8'(w*3), 8'(w*5), 8'(w*7)};
    fill_expected();
    clear_frame();
    stray_en = 1;
    fork
      begin
        pulse_start();
        wait_done(seen, at);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          repeat (60) @(negedge clk);
          if (bus.busy === 1'b1) bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
    join
    stray_en = 0;
    repeat (5) @(negedge clk);
    n_checks++; if (!seen) $display("FAIL ign_frame_done: got 0 expected 1"); else n_pass++;
    n_checks++; if (rx_q.size() != 34) $display("FAIL ign_len: got %0d expected 34", rx_q.size()); else n_pass++;
    for (int i = 0; i < 34; i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== exp_b[i]) $display("FAIL ign_byte%0d: got %h expected %h", i, g, exp_b[i]); else n_pass++;
    end
    repeat (100) @(negedge clk);
    n_checks++; if (rd_cnt != 8) $display("FAIL ign_rd_en_count: got %0d expected 8", rd_cnt); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL ign_frame_done_count: got %0d expected 1", fd_cnt); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL ign_busy_after: got %b expected 0", bus.busy); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit seen; int at;
    for (int w = 0; w < 8; w++) words[w] = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
    fill_expected();
    clear_frame();
    pulse_start();
    // Byte 10 (0x09) starts 407 cycles after the start cycle; data bit 1
    // (value 0) covers cycles 415..418.
    repeat (415) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b0) $display("FAIL rm_pre_tx: got %b expected 0", bus.tx); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.tx !== 1'b1) $display("FAIL rm_tx: got %b expected 1", bus.tx); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.rd_en !== 1'b0) $display("FAIL rm_rd_en: got %b expected 0", bus.rd_en); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL rm_frame_done: got %b expected 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL rm_timeout_err: got %b expected 0", bus.timeout_err); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) $display("FAIL rm_not_resumed: got tx=%b busy=%b expected tx=1 busy=0", bus.tx, bus.busy); else n_pass++;
    clear_frame();
    pulse_start();
    wait_done(seen, at);
    repeat (5) @(negedge clk);
    n_checks++; if (!seen) $display("FAIL rm_frame_done: got 0 expected 1"); else n_pass++;
    n_checks++; if (rx_q.size() != 34) $display("FAIL rm_len: got %0d expected 34", rx_q.size()); else n_pass++;
    for (int i = 0; i < 34; i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_checks++; if (g !== exp_b[i]) $display("FAIL rm_byte%0d: got %h expected %h", i, g, exp_b[i]); else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_incrementing();
    test_all_ff();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
